// File: rtl/qupls_checkpoint_ctrl.sv
// Register-alias-table checkpoint controller for the Q+ rename stage.
// Checkpoints form a circular queue: one is allocated at the tail for each
// queued branch and retired at the head when that branch commits. A branch
// miss rolls the tail back to just past the missed branch and runs a short
// restore sequence that strobes the RAT to reload its map.
module qupls_checkpoint_ctrl #(
  parameter int unsigned NCHK           = 16,
  parameter int unsigned RESTORE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_req,
  output logic                    alloc_gnt,
  output logic [$clog2(NCHK)-1:0] alloc_cp,
  input  logic                    cmt_br,
  input  logic                    miss,
  input  logic [$clog2(NCHK)-1:0] miss_cp,
  output logic [$clog2(NCHK)-1:0] cndx,
  output logic                    restore,
  output logic [$clog2(NCHK)-1:0] restore_cp,
  output logic                    busy,
  output logic                    stallq,
  output logic [$clog2(NCHK):0]   count,
  output logic                    err
);

  localparam int unsigned W = $clog2(NCHK);

  typedef enum logic [1:0] {
    IDLE,
    RESTORE,
    RESUME
  } state_t;

  state_t         state;
  logic [W-1:0]   head;
  logic [W-1:0]   tail;
  logic [2:0]     timer;

  logic           commit;
  logic [W-1:0]   head_nxt;
  logic [W:0]     count_cmt;
  logic [W-1:0]   age;
  logic [W-1:0]   rcp_age;
  logic           miss_valid;
  logic           miss_take;

  // Miss ages are measured from the head as it stands after a same-cycle
  // commit, so the age range [0, count_cmt) covers exactly the branches that
  // are still outstanding once that commit has retired the oldest one.
  always_comb begin
    commit     = cmt_br && (count != '0);
    head_nxt   = head + W'(commit);
    count_cmt  = count - (W+1)'(commit);
    age        = miss_cp - head_nxt;
    rcp_age    = restore_cp - head_nxt;
    miss_valid = miss && ({1'b0, age} < count_cmt);
    miss_take  = miss_valid && ((state != RESTORE) || (age < rcp_age));
  end

  // Grant and stall decisions are made combinationally from current state.
  always_comb begin
    alloc_gnt = alloc_req && (state == IDLE) && (count < (W+1)'(NCHK)) && !miss;
    alloc_cp  = tail;
    stallq    = (alloc_req && !alloc_gnt) || (state != IDLE);
    busy      = (state != IDLE);
  end

  // Queue pointers, restore sequencing and sticky error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      timer      <= '0;
      cndx       <= '0;
      restore    <= 1'b0;
      restore_cp <= '0;
      err        <= 1'b0;
    end else begin
      restore <= 1'b0;
      head    <= head_nxt;
      if ((cmt_br && (count == '0)) || (miss && !miss_valid))
        err <= 1'b1;
      if (miss_take) begin
        // The missed branch itself stays outstanding; everything younger
        // is discarded by pulling the tail back behind it.
        tail       <= miss_cp + W'(1);
        count      <= {1'b0, age} + (W+1)'(1);
        cndx       <= miss_cp;
        restore_cp <= miss_cp;
        restore    <= 1'b1;
        state      <= RESTORE;
        timer      <= 3'(RESTORE_CYCLES - 1);
      end else begin
        if (alloc_gnt) begin
          tail <= tail + W'(1);
          cndx <= tail;
        end
        count <= count_cmt + (W+1)'(alloc_gnt);
        case (state)
          RESTORE: begin
            if (timer == '0)
              state <= RESUME;
            else
              timer <= timer - 3'd1;
          end
          RESUME:  state <= IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qupls_checkpoint_ctrl.sv
// Self-checking bench for qupls_checkpoint_ctrl: a directed vector table,
// hand-written corner sequences and a randomized run against a queue model.
module tb_qupls_checkpoint_ctrl;

  localparam int NCHK = 16;
  localparam int RC   = 2;
  localparam int W    = $clog2(NCHK);

  logic         clk = 1'b0;
  logic         rst;
  logic         alloc_req;
  logic         alloc_gnt;
  logic [W-1:0] alloc_cp;
  logic         cmt_br;
  logic         miss;
  logic [W-1:0] miss_cp;
  logic [W-1:0] cndx;
  logic         restore;
  logic [W-1:0] restore_cp;
  logic         busy;
  logic         stallq;
  logic [W:0]   count;
  logic         err;

  qupls_checkpoint_ctrl #(
    .NCHK(NCHK),
    .RESTORE_CYCLES(RC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alloc_req(alloc_req),
    .alloc_gnt(alloc_gnt),
    .alloc_cp(alloc_cp),
    .cmt_br(cmt_br),
    .miss(miss),
    .miss_cp(miss_cp),
    .cndx(cndx),
    .restore(restore),
    .restore_cp(restore_cp),
    .busy(busy),
    .stallq(stallq),
    .count(count),
    .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: the outstanding checkpoints as an ordered queue
  // (oldest first) and a count of remaining stalled cycles after a miss.
  int q[$];
  int m_tail, m_cndx, m_rcp, m_hold;
  bit m_restore, m_err;
  bit e_gnt, e_stall;
  int e_acp;

  task automatic model_reset();
    q.delete();
    m_tail = 0; m_cndx = 0; m_rcp = 0; m_hold = 0;
    m_restore = 0; m_err = 0;
  endtask

  function automatic int qpos(input int cp);
    foreach (q[i]) if (q[i] == cp) return i;
    return -1;
  endfunction

  task automatic model_comb(input bit req, input bit mi);
    e_gnt   = req && (m_hold == 0) && (q.size() < NCHK) && !mi;
    e_acp   = m_tail;
    e_stall = (req && !e_gnt) || (m_hold > 0);
  endtask

  task automatic model_step(input bit cmt, input bit mi, input int mcp);
    bit in_restore = (m_hold > 1);
    int p, rp;
    m_restore = 0;
    if (m_hold > 0) m_hold--;
    if (cmt) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_err = 1;
    end
    if (mi) begin
      p = qpos(mcp);
      if (p < 0) m_err = 1;
      else begin
        rp = qpos(m_rcp);
        if (!in_restore || rp < 0 || p < rp) begin
          while (q.size() > p + 1) void'(q.pop_back());
          m_tail = (mcp + 1) % NCHK;
          m_cndx = mcp;
          m_rcp = mcp;
          m_restore = 1;
          m_hold = RC + 1;
        end
      end
    end else if (e_gnt) begin
      q.push_back(m_tail);
      m_cndx = m_tail;
      m_tail = (m_tail + 1) % NCHK;
    end
  endtask

  logic         s_gnt, s_stall;
  logic [W-1:0] s_acp;

  task automatic do_cycle(input bit req, input bit cmt, input bit mi, input int mcp);
    alloc_req = req;
    cmt_br    = cmt;
    miss      = mi;
    miss_cp   = W'(mcp);
    #1;
    model_comb(req, mi);
    s_gnt   = alloc_gnt;
    s_acp   = alloc_cp;
    s_stall = stallq;
    chk("m_gnt", alloc_gnt, e_gnt);
    if (e_gnt) chk("m_alloc_cp", alloc_cp, e_acp);
    chk("m_stallq", stallq, e_stall);
    @(posedge clk);
    model_step(cmt, mi, mcp);
    #1;
    chk("m_count", count, q.size());
    chk("m_cndx", cndx, m_cndx);
    chk("m_restore", restore, m_restore);
    chk("m_restore_cp", restore_cp, m_rcp);
    chk("m_busy", busy, m_hold > 0);
    chk("m_err", err, m_err);
  endtask

  task automatic do_reset();
    rst = 1'b1; alloc_req = 0; cmt_br = 0; miss = 0; miss_cp = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit req, cmt, mi; int mcp;
    bit gnt; int acp; bit st;
    int cnt, cx; bit rs; int rcp; bit bz, er;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, c, m, input int mcp, input bit g, input int acp, input bit st,
                     input int cnt, cx, input bit rs, input int rcp, input bit bz, er);
    vec_t v;
    v.req = r; v.cmt = c; v.mi = m; v.mcp = mcp;
    v.gnt = g; v.acp = acp; v.st = st;
    v.cnt = cnt; v.cx = cx; v.rs = rs; v.rcp = rcp; v.bz = bz; v.er = er;
    vecs.push_back(v);
  endtask

  initial begin
    int mcp;
    // req cmt miss mcp | gnt acp stall | count cndx restore rcp busy err
    add(1,0,0,0, 1,0,0, 1,0,0,0,0,0);
    add(1,0,0,0, 1,1,0, 2,1,0,0,0,0);
    add(1,0,0,0, 1,2,0, 3,2,0,0,0,0);
    add(1,0,0,0, 1,3,0, 4,3,0,0,0,0);
    add(1,0,0,0, 1,4,0, 5,4,0,0,0,0);
    add(0,0,1,2, 0,0,0, 3,2,1,2,1,0);
    add(1,0,0,0, 0,0,1, 3,2,0,2,1,0);
    add(1,0,0,0, 0,0,1, 3,2,0,2,1,0);
    add(1,0,0,0, 0,0,1, 3,2,0,2,0,0);
    add(1,0,0,0, 1,3,0, 4,3,0,2,0,0);
    add(0,0,1,3, 0,0,0, 4,3,1,3,1,0);
    add(0,0,1,1, 0,0,1, 2,1,1,1,1,0);
    add(0,0,1,1, 0,0,1, 2,1,0,1,1,0);
    add(0,0,0,0, 0,0,1, 2,1,0,1,1,0);
    add(0,0,0,0, 0,0,1, 2,1,0,1,0,0);
    add(0,0,0,0, 0,0,0, 2,1,0,1,0,0);
    add(0,1,0,0, 0,0,0, 1,1,0,1,0,0);
    add(0,1,0,0, 0,0,0, 0,1,0,1,0,0);
    add(0,1,0,0, 0,0,0, 0,1,0,1,0,1);
    add(0,0,0,0, 0,0,0, 0,1,0,1,0,1);

    do_reset();
    chk("reset count", count, 0);
    chk("reset cndx", cndx, 0);
    chk("reset restore", restore, 0);
    chk("reset restore_cp", restore_cp, 0);
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);

    foreach (vecs[i]) begin
      do_cycle(vecs[i].req, vecs[i].cmt, vecs[i].mi, vecs[i].mcp);
      chk($sformatf("row%0d gnt", i), s_gnt, vecs[i].gnt);
      if (vecs[i].gnt) chk($sformatf("row%0d alloc_cp", i), s_acp, vecs[i].acp);
      chk($sformatf("row%0d stallq", i), s_stall, vecs[i].st);
      chk($sformatf("row%0d count", i), count, vecs[i].cnt);
      chk($sformatf("row%0d cndx", i), cndx, vecs[i].cx);
      chk($sformatf("row%0d restore", i), restore, vecs[i].rs);
      chk($sformatf("row%0d restore_cp", i), restore_cp, vecs[i].rcp);
      chk($sformatf("row%0d busy", i), busy, vecs[i].bz);
      chk($sformatf("row%0d err", i), err, vecs[i].er);
    end

    // Fill to full, then full with a same-cycle commit, then wrap.
    do_reset();
    for (int i = 0; i < NCHK; i++) begin
      do_cycle(1, 0, 0, 0);
      chk($sformatf("fill cp%0d", i), s_acp, i);
    end
    chk("full count", count, NCHK);
    do_cycle(1, 0, 0, 0);
    chk("full gnt", s_gnt, 0);
    chk("full stallq", s_stall, 1);
    chk("full cndx", cndx, NCHK - 1);
    do_cycle(1, 1, 0, 0);
    chk("full+cmt gnt", s_gnt, 0);
    chk("full+cmt count", count, NCHK - 1);
    do_cycle(1, 0, 0, 0);
    chk("wrap gnt", s_gnt, 1);
    chk("wrap alloc_cp", s_acp, 0);
    chk("wrap count", count, NCHK);
    chk("wrap cndx", cndx, 0);

    // Miss beyond the outstanding range.
    do_reset();
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 0, 0);
    do_cycle(0, 0, 1, 4);
    chk("badmiss err", err, 1);
    chk("badmiss count", count, 3);
    chk("badmiss restore", restore, 0);

    // Reset while restoring aborts the restore.
    do_reset();
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 0, 0);
    do_cycle(0, 0, 1, 1);
    chk("pre-rst restore", restore, 1);
    do_reset();
    chk("rst-restore busy", busy, 0);
    chk("rst-restore restore", restore, 0);
    chk("rst-restore count", count, 0);
    do_cycle(1, 0, 0, 0);
    chk("post-rst restore", restore, 0);
    chk("post-rst alloc_cp", s_acp, 0);

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      bit r, c, m;
      r = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 99) < 35);
      m = ($urandom_range(0, 99) < 7);
      if (q.size() > 0 && $urandom_range(0, 2) != 0)
        mcp = q[$urandom_range(0, q.size() - 1)];
      else
        mcp = $urandom_range(0, NCHK - 1);
      do_cycle(r, c, m, mcp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qupls_checkpoint_ctrl.md
Name: qupls_checkpoint_ctrl

Overview:
Allocates, retires and restores register-alias-table checkpoints for the Q+ rename stage. Checkpoints are kept as a circular queue: one per queued branch, allocated at the tail and retired at the head on branch commit. The tail is rolled back on a branch miss. The block drives the checkpoint index and restore strobes into the RAT, and stalls enqueue when checkpoints run out or a restore is in progress.

Parameters:
NCHK, 16, number of checkpoints; power of two, 4..32
RESTORE_CYCLES, 2, cycles the rename stage is held in RESTORE after a miss; 1..7

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_req  in  1  branch being enqueued this cycle; needs a checkpoint
alloc_gnt  out  1  checkpoint granted this cycle (combinational)
alloc_cp  out  $clog2(NCHK)  index granted; valid with alloc_gnt
cmt_br  in  1  oldest outstanding branch commits; frees the head checkpoint
miss  in  1  branch miss reported
miss_cp  in  $clog2(NCHK)  checkpoint index of the missed branch
cndx  out  $clog2(NCHK)  current checkpoint index to the RAT (registered)
restore  out  1  one-cycle strobe to the RAT to reload map from restore_cp (registered)
restore_cp  out  $clog2(NCHK)  checkpoint to restore (registered)
busy  out  1  FSM not in IDLE
stallq  out  1  hold enqueue (combinational)
count  out  $clog2(NCHK)+1  outstanding checkpoints, 0..NCHK
err  out  1  sticky protocol error

Behaviour:
- State: head, tail (mod NCHK); count; FSM {IDLE, RESTORE, RESUME}; restore timer (3 bits).
- Reset values:
  - head, tail, count, cndx, restore_cp = 0
  - restore, busy, err = 0
  - FSM = IDLE
  - A reset asserted mid-RESTORE aborts the restore immediately; no restore strobe follows.
- Grant: alloc_gnt = alloc_req & FSM==IDLE & count<NCHK & !miss.
  - On grant: alloc_cp = tail; tail <= tail+1; cndx <= tail (combinationally equal to alloc_cp).
  - One grant maximum per cycle.
- stallq = alloc_req & !alloc_gnt, or FSM!=IDLE.
- Commit: cmt_br with count>0 gives head <= head+1, count <= count-1.
  - cmt_br with count==0 is ignored and sets err.
- Count update per cycle: count + grant - commit. Grant and commit in the same cycle leave count unchanged.
- Full: count==NCHK gives no grant. A commit in the same cycle does not enable a grant; the grant takes effect the next cycle.
- Miss validity: miss is valid only if age = (miss_cp - head) mod NCHK is < count, where count is the value after applying a same-cycle commit. An invalid miss is ignored and sets err.
- Valid miss, in any FSM state (cycle N):
  - tail <= miss_cp+1; count <= age+1. The missed branch stays outstanding.
  - cndx <= miss_cp; restore_cp <= miss_cp.
  - FSM <= RESTORE; timer <= RESTORE_CYCLES-1.
  - restore is asserted in cycle N+1 only.
- Second miss during RESTORE:
  - If strictly older (smaller age) than the current restore_cp: re-applies as above, re-strobes restore and reloads the timer.
  - Otherwise it is ignored (no err).
- Transitions:
  - RESTORE: decrement timer; at 0, go to RESUME.
  - RESUME: one cycle, then IDLE. busy is deasserted once in IDLE.
  - Enqueue is stalled for RESTORE_CYCLES+1 cycles after the miss cycle.
- Wrap-around: head and tail wrap modulo NCHK. count, not head==tail, distinguishes full from empty.
- Commit during RESTORE/RESUME is allowed and advances head.

Test Plan:
- Reset, then 16 alloc_req in consecutive cycles -> alloc_cp 0..15 granted, count=16. 17th request -> alloc_gnt=0, stallq=1, cndx=15.
- Full with cmt_br and alloc_req in the same cycle -> no grant that cycle; next cycle grant with alloc_cp=0 (wrap), head=1, count=16.
- Allocate 5 (cp0..4), miss with miss_cp=2 -> next cycle restore=1, restore_cp=2, cndx=2, count=3. stallq high 3 cycles (RESTORE_CYCLES=2). Next grant gives alloc_cp=3.
- During RESTORE for cp3 (head=0), miss_cp=1 -> restore re-strobed with restore_cp=1, count=2, timer reloaded. A later miss_cp=1 -> ignored.
- cmt_br with count=0 -> count stays 0, err=1 and sticky. miss_cp=4 with head=0, count=3 -> ignored, err=1.
- rst asserted during RESTORE -> next cycle FSM=IDLE, busy=0, restore=0, count=0, head=tail=0.
